// File: rtl/fetch_decode_queue.sv
// Fetch-to-decode instruction queue: DEPTH-entry {pc, instr} buffer with
// valid/ready handshakes, flush on redirect, and immediate-format decode of the head.
module fetch_decode_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [XLEN-1:0]            in_pc,
  input  logic [XLEN-1:0]            in_instr,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            out_pc,
  output logic [24:0]                out_instr,
  output logic [6:0]                 out_rd_opcode,
  output logic [1:0]                 out_immsrc,
  output logic                       out_illegal,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [XLEN-1:0] instr_mem [DEPTH];
  logic [PW-1:0]   rd_ptr_reg;
  logic [PW-1:0]   wr_ptr_reg;
  logic [CW-1:0]   count_reg;

  logic push;
  logic pop;

  // Ready/valid depend only on the registered occupancy, never on the far side's handshake.
  assign in_ready  = (count_reg != CW'(DEPTH));
  assign out_valid = (count_reg != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign count     = count_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage carries no reset; stale contents are hidden by the empty-output gating below.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (push && !flush && (wr_ptr_reg == PW'(gi))) begin
          pc_mem[gi]    <= in_pc;
          instr_mem[gi] <= in_instr;
        end
      end
    end
  endgenerate

  logic [XLEN-1:0] head_pc;
  logic [XLEN-1:0] head_instr;
  logic [1:0]      head_immsrc;
  logic            head_illegal;

  assign head_pc    = pc_mem[rd_ptr_reg];
  assign head_instr = instr_mem[rd_ptr_reg];

  always_comb begin
    head_immsrc  = 2'b00;
    head_illegal = 1'b0;
    case (head_instr[6:0])
      7'b0000011, 7'b0010011, 7'b1100111: head_immsrc = 2'b00;
      7'b0100011:                         head_immsrc = 2'b01;
      7'b1100011:                         head_immsrc = 2'b10;
      7'b0110011:                         head_immsrc = 2'b00;
      default: begin
        head_immsrc  = 2'b11;
        head_illegal = 1'b1;
      end
    endcase
  end

  assign out_pc        = out_valid ? head_pc           : '0;
  assign out_instr     = out_valid ? head_instr[31:7]  : '0;
  assign out_rd_opcode = out_valid ? head_instr[6:0]   : '0;
  assign out_immsrc    = out_valid ? head_immsrc       : '0;
  assign out_illegal   = out_valid ? head_illegal      : 1'b0;

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Self-checking bench for fetch_decode_queue: directed steps plus random traffic
// compared against a queue-based reference model.
module tb_fetch_decode_queue;
  localparam int DEPTH = 4;
  localparam int XLEN  = 32;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_instr;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [24:0]     out_instr;
  logic [6:0]      out_rd_opcode;
  logic [1:0]      out_immsrc;
  logic            out_illegal;
  logic [CW-1:0]   count;

  fetch_decode_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_instr(out_instr), .out_rd_opcode(out_rd_opcode),
    .out_immsrc(out_immsrc), .out_illegal(out_illegal), .count(count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: plain FIFO of (pc, instr) pairs.
  logic [31:0] q_pc[$];
  logic [31:0] q_instr[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] ref_decode(input logic [6:0] op);
    // returns {illegal, immsrc}
    case (op)
      7'h03, 7'h13, 7'h67: return 3'b000;
      7'h23:               return 3'b001;
      7'h63:               return 3'b010;
      7'h33:               return 3'b000;
      default:             return 3'b111;
    endcase
  endfunction

  task automatic check_all(input string tag);
    int n;
    logic [31:0] hi;
    logic [2:0]  d;
    n = q_pc.size();
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(n != 0));
    chk({tag, ".in_ready"},  32'(in_ready),  32'(n != DEPTH));
    chk({tag, ".count"},     32'(count),     32'(n));
    if (n != 0) begin
      hi = q_instr[0];
      d  = ref_decode(hi[6:0]);
      chk({tag, ".out_pc"},     out_pc,                q_pc[0]);
      chk({tag, ".out_instr"},  32'(out_instr),        hi >> 7);
      chk({tag, ".out_opcode"}, 32'(out_rd_opcode),    hi & 32'h7F);
      chk({tag, ".out_immsrc"}, 32'(out_immsrc),       32'(d[1:0]));
      chk({tag, ".out_illegal"},32'(out_illegal),      32'(d[2]));
    end else begin
      chk({tag, ".out_pc"},     out_pc,             32'h0);
      chk({tag, ".out_instr"},  32'(out_instr),     32'h0);
      chk({tag, ".out_opcode"}, 32'(out_rd_opcode), 32'h0);
      chk({tag, ".out_immsrc"}, 32'(out_immsrc),    32'h0);
      chk({tag, ".out_illegal"},32'(out_illegal),   32'h0);
    end
  endtask

  // One clock edge: model decides push/pop from pre-edge state, then outputs are checked.
  task automatic tick(input string tag);
    bit do_push, do_pop;
    do_pop  = out_ready && (q_pc.size() > 0);
    do_push = in_valid && (q_pc.size() < DEPTH);
    @(posedge clk);
    if (!reset_n || flush) begin
      q_pc.delete();
      q_instr.delete();
    end else begin
      if (do_pop) begin
        $display("pop  pc=%h instr=%h", q_pc[0], q_instr[0]);
        void'(q_pc.pop_front());
        void'(q_instr.pop_front());
      end
      if (do_push) begin
        q_pc.push_back(in_pc);
        q_instr.push_back(in_instr);
      end
    end
    #1;
    check_all(tag);
  endtask

  task automatic idle();
    flush = 0; in_valid = 0; out_ready = 0; in_pc = '0; in_instr = '0;
  endtask

  initial begin
    logic [31:0] fmt[4];
    logic [6:0]  ops[7];
    logic [31:0] r;
    fmt[0] = 32'h00112623; fmt[1] = 32'h00208463; fmt[2] = 32'h0000a103; fmt[3] = 32'h0000007F;
    ops[0] = 7'h03; ops[1] = 7'h13; ops[2] = 7'h67; ops[3] = 7'h23;
    ops[4] = 7'h63; ops[5] = 7'h33; ops[6] = 7'h00;

    // Reset held with traffic offered.
    idle();
    reset_n = 0; in_valid = 1; in_pc = 32'h100; in_instr = 32'h00500093;
    for (int i = 0; i < 3; i++) tick("reset");
    reset_n = 1;
    in_valid = 1; in_pc = 32'h0; in_instr = 32'h00500093;
    tick("first_push");
    idle(); out_ready = 1;
    tick("first_pop");

    // Fill past full with decode stalled, then drain.
    idle();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1; in_pc = 32'(i * 4); in_instr = 32'h00000013 | 32'(i << 7);
      tick("fill");
    end
    idle(); out_ready = 1;
    for (int i = 0; i < 4; i++) tick("drain");

    // Continuous streaming with both sides always ready.
    for (int i = 0; i < 20; i++) begin
      in_valid = 1; out_ready = 1; in_pc = 32'h1000 + 32'(i * 4);
      r = $urandom(); in_instr = {r[31:7], 7'h13};
      tick("stream");
    end
    idle(); out_ready = 1;
    tick("stream_tail");

    // Immediate-format decode of each head.
    idle();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1; in_pc = 32'h2000 + 32'(i * 4); in_instr = fmt[i];
      tick("fmt_push");
    end
    idle(); out_ready = 1;
    for (int i = 0; i < 4; i++) tick("fmt_pop");

    // Flush wins over a simultaneous push and pop.
    idle();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; in_pc = 32'h3000 + 32'(i * 4); in_instr = 32'h00000063;
      tick("pre_flush");
    end
    flush = 1; in_valid = 1; out_ready = 1; in_pc = 32'hDEAD0000; in_instr = 32'h00000023;
    tick("flush");
    idle(); out_ready = 1;
    tick("post_flush");

    // Asynchronous reset between edges.
    idle();
    for (int i = 0; i < 2; i++) begin
      in_valid = 1; in_pc = 32'h4000 + 32'(i * 4); in_instr = 32'h00000003;
      tick("pre_areset");
    end
    idle();
    #1;
    reset_n = 0;
    q_pc.delete(); q_instr.delete();
    #1;
    check_all("async_reset");
    @(negedge clk);
    reset_n = 1;
    tick("after_areset");

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      r = $urandom();
      in_valid  = r[0] | r[1];
      out_ready = r[2] | r[3];
      flush     = (r[7:4] == 4'h0);
      in_pc     = 32'h8000 + 32'(i * 4);
      r = $urandom();
      in_instr  = {r[31:7], (r[2:0] == 3'd7) ? r[6:0] : ops[r[2:0]]};
      tick("random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
